seq_counter: RTL and testbench



---
 rtl/seq_counter.sv | 150 +++++++++++++++
 tb/tb_seq_counter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_counter.sv
// rtl/seq_counter.sv - sequence counter and timing-state controller for the CPU control unit
//
// Generates the n-bit timing index that drives the timing decoder, tracks the
// IDLE/RUN/HALTED execution state, counts completed instructions and raises a
// sticky flag when an instruction runs past the last legal timing index.
//
// Optional feature: define SEQ_SINGLE_STEP_EN to add single-step control.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   start request (IDLE/HALTED -> RUN)
//   hlt        in   halt request from control logic
//   clr_sc     in   end of instruction, timing index restarts at T0
//   ovf_clr    in   clears the sticky overrun flag
//   step_mode  in   (SEQ_SINGLE_STEP_EN) single-step mode enable
//   step_req   in   (SEQ_SINGLE_STEP_EN) step request, rising edge advances
//   sc         out  timing index to the decoder ilines
//   run        out  high while in RUN
//   halted     out  high while in HALTED
//   ovf        out  sticky overrun flag
//   icount     out  completed-instruction count (wraps)

module seq_counter #(
  parameter int n    = 4,
  parameter int MAXT = (2 ** n) - 1,
  parameter int ICW  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           hlt,
  input  logic           clr_sc,
  input  logic           ovf_clr,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic           step_mode,
  input  logic           step_req,
`endif
  output logic [n-1:0]   sc,
  output logic           run,
  output logic           halted,
  output logic           ovf,
  output logic [ICW-1:0] icount
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [n-1:0] MAXT_SC = n'(MAXT);

  state_t         state;
  state_t         state_next;
  logic [n-1:0]   sc_next;
  logic [ICW-1:0] icount_next;
  logic           ovf_set;
  logic           ovf_next;
  logic           advance;

`ifdef SEQ_SINGLE_STEP_EN
  // Two-stage history of step_req; the edge is seen one cycle after the
  // request is first sampled, which keeps the step path fully registered.
  logic step_d1;
  logic step_d2;
  logic step_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_d1 <= 1'b0;
      step_d2 <= 1'b0;
    end else begin
      step_d1 <= step_req;
      step_d2 <= step_d1;
    end
  end

  assign step_edge = step_d1 & ~step_d2;
`endif

  always_comb begin
`ifdef SEQ_SINGLE_STEP_EN
    advance = !step_mode || step_edge;
`else
    advance = 1'b1;
`endif
  end

  always_comb begin
    state_next  = state;
    sc_next     = sc;
    icount_next = icount;
    ovf_set     = 1'b0;
    case (state)
      IDLE: begin
        sc_next = '0;
        if (start) state_next = RUN;
      end
      RUN: begin
        // Without a step edge in step mode nothing moves and hlt/clr_sc are dropped.
        if (advance) begin
          if (hlt) begin
            state_next  = HALTED;
            sc_next     = '0;
            icount_next = icount + ICW'(1);
          end else if (clr_sc) begin
            sc_next     = '0;
            icount_next = icount + ICW'(1);
          end else if (sc < MAXT_SC) begin
            sc_next = sc + n'(1);
          end else begin
            // Ran past the last timing slot: restart at T0, not a completed instruction.
            sc_next = '0;
            ovf_set = 1'b1;
          end
        end
      end
      HALTED: begin
        sc_next = '0;
        if (start) state_next = RUN;
      end
      default: begin
        state_next = IDLE;
        sc_next    = '0;
      end
    endcase
    // A new overrun beats a simultaneous clear.
    ovf_next = ovf_set | (ovf & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sc     <= '0;
      run    <= 1'b0;
      halted <= 1'b0;
      ovf    <= 1'b0;
      icount <= '0;
    end else begin
      state  <= state_next;
      sc     <= sc_next;
      run    <= (state_next == RUN);
      halted <= (state_next == HALTED);
      ovf    <= ovf_next;
      icount <= icount_next;
    end
  end

endmodule

// File: tb/tb_seq_counter.sv
// tb/tb_seq_counter.sv - directed self-checking bench for seq_counter

module tb_seq_counter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        hlt;
  logic        clr_sc;
  logic        ovf_clr;
  logic [3:0]  sc;
  logic        run;
  logic        halted;
  logic        ovf;
  logic [15:0] icount;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step_mode;
  logic        step_req;
`endif

  int pass_cnt;
  int total_cnt;

  seq_counter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .hlt       (hlt),
    .clr_sc    (clr_sc),
    .ovf_clr   (ovf_clr),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode (step_mode),
    .step_req  (step_req),
`endif
    .sc        (sc),
    .run       (run),
    .halted    (halted),
    .ovf       (ovf),
    .icount    (icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge, then return to the falling edge where outputs are sampled
  // and inputs are changed.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Run freely until sc reaches target; a missed target is a failed comparison.
  task automatic run_to(input logic [3:0] target);
    int k;
    k = 0;
    while (sc !== target && k < 40) begin
      tick();
      k++;
    end
    total_cnt++;
    if (sc !== target) $display("FAIL run_to: sc=%0d required %0d", sc, target);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; hlt = 1'b0; clr_sc = 1'b0; ovf_clr = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step_mode = 1'b0; step_req = 1'b0;
`endif
    tick(); tick();
    total_cnt++;
    if ({sc, run, halted, ovf, icount} !== 23'd0)
      $display("FAIL reset: sc=%0d run=%0b halted=%0b ovf=%0b icount=%0d required all 0",
               sc, run, halted, ovf, icount);
    else pass_cnt++;
    rst_n = 1'b1;
    // hlt/clr_sc must be ignored in IDLE
    hlt = 1'b1; clr_sc = 1'b1;
    tick(); tick();
    hlt = 1'b0; clr_sc = 1'b0;
    total_cnt++;
    if (sc !== 4'd0 || run !== 1'b0 || halted !== 1'b0 || icount !== 16'd0)
      $display("FAIL idle_ignore: sc=%0d run=%0b halted=%0b icount=%0d required 0 0 0 0",
               sc, run, halted, icount);
    else pass_cnt++;
  endtask

  task automatic test_free_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++;
    if (run !== 1'b1 || sc !== 4'd0)
      $display("FAIL start: run=%0b sc=%0d required 1 0", run, sc);
    else pass_cnt++;
    for (int i = 1; i <= 15; i++) begin
      tick();
      total_cnt++;
      if (sc !== 4'(i) || ovf !== 1'b0)
        $display("FAIL free_run_%0d: sc=%0d ovf=%0b required %0d 0", i, sc, ovf, i);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (sc !== 4'd0 || ovf !== 1'b1 || icount !== 16'd0 || run !== 1'b1)
      $display("FAIL overrun_wrap: sc=%0d ovf=%0b icount=%0d run=%0b required 0 1 0 1",
               sc, ovf, icount, run);
    else pass_cnt++;
  endtask

  task automatic test_clr_sc();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    total_cnt++;
    if (ovf !== 1'b0 || sc !== 4'd1)
      $display("FAIL ovf_clr_plain: ovf=%0b sc=%0d required 0 1", ovf, sc);
    else pass_cnt++;
    for (int k = 1; k <= 5; k++) begin
      run_to(4'd3);
      clr_sc = 1'b1;
      tick();
      clr_sc = 1'b0;
      total_cnt++;
      if (sc !== 4'd0 || icount !== 16'(k))
        $display("FAIL clr_sc_%0d: sc=%0d icount=%0d required 0 %0d", k, sc, icount, k);
      else pass_cnt++;
    end
    total_cnt++;
    if (icount !== 16'd5 || ovf !== 1'b0)
      $display("FAIL clr_sc_total: icount=%0d ovf=%0b required 5 0", icount, ovf);
    else pass_cnt++;
  endtask

  task automatic test_halt();
    run_to(4'd4);
    hlt = 1'b1; clr_sc = 1'b1;
    tick();
    hlt = 1'b0; clr_sc = 1'b0;
    total_cnt++;
    if (sc !== 4'd0 || run !== 1'b0 || halted !== 1'b1 || icount !== 16'd6)
      $display("FAIL halt: sc=%0d run=%0b halted=%0b icount=%0d required 0 0 1 6",
               sc, run, halted, icount);
    else pass_cnt++;
    // Held in HALTED, hlt/clr_sc have no effect
    hlt = 1'b1; clr_sc = 1'b1;
    tick(); tick(); tick();
    hlt = 1'b0; clr_sc = 1'b0;
    total_cnt++;
    if (sc !== 4'd0 || halted !== 1'b1 || icount !== 16'd6)
      $display("FAIL halted_hold: sc=%0d halted=%0b icount=%0d required 0 1 6",
               sc, halted, icount);
    else pass_cnt++;
    start = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++;
    if (run !== 1'b1 || halted !== 1'b0 || sc !== 4'd0)
      $display("FAIL restart: run=%0b halted=%0b sc=%0d required 1 0 0", run, halted, sc);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (sc !== 4'd1) $display("FAIL restart_count: sc=%0d required 1", sc);
    else pass_cnt++;
  endtask

  task automatic test_ovf_clear();
    run_to(4'd15);
    tick();
    total_cnt++;
    if (ovf !== 1'b1 || sc !== 4'd0)
      $display("FAIL ovf_set: ovf=%0b sc=%0d required 1 0", ovf, sc);
    else pass_cnt++;
    run_to(4'd15);
    ovf_clr = 1'b1;
    tick();
    total_cnt++;
    if (ovf !== 1'b1 || sc !== 4'd0)
      $display("FAIL ovf_set_wins: ovf=%0b sc=%0d required 1 0", ovf, sc);
    else pass_cnt++;
    tick();
    ovf_clr = 1'b0;
    total_cnt++;
    if (ovf !== 1'b0 || sc !== 4'd1 || icount !== 16'd6)
      $display("FAIL ovf_clear_next: ovf=%0b sc=%0d icount=%0d required 0 1 6",
               ovf, sc, icount);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    run_to(4'd7);
    #2;
    rst_n = 1'b0;
    #1;
    // Still 2 time units before the next rising edge
    total_cnt++;
    if (sc !== 4'd0 || run !== 1'b0 || icount !== 16'd0 || halted !== 1'b0 || ovf !== 1'b0)
      $display("FAIL async_reset: sc=%0d run=%0b icount=%0d halted=%0b ovf=%0b required 0 0 0 0 0",
               sc, run, icount, halted, ovf);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if (run !== 1'b0 || sc !== 4'd0)
      $display("FAIL post_reset_idle: run=%0b sc=%0d required 0 0", run, sc);
    else pass_cnt++;
  endtask

`ifdef SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    start = 1'b1;
    tick();
    start = 1'b0;
    step_mode = 1'b1;
    tick(); tick(); tick();
    total_cnt++;
    if (sc !== 4'd0 || run !== 1'b1)
      $display("FAIL step_idle_hold: sc=%0d run=%0b required 0 1", sc, run);
    else pass_cnt++;
    for (int p = 1; p <= 3; p++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      total_cnt++;
      if (sc !== 4'(p - 1))
        $display("FAIL step_delay_%0d: sc=%0d required %0d", p, sc, p - 1);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (sc !== 4'(p))
        $display("FAIL step_advance_%0d: sc=%0d required %0d", p, sc, p);
      else pass_cnt++;
      for (int j = 0; j < 8; j++) tick();
      total_cnt++;
      if (sc !== 4'(p))
        $display("FAIL step_hold_%0d: sc=%0d required %0d", p, sc, p);
      else pass_cnt++;
    end
    step_mode = 1'b0;
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_free_run();
    test_clr_sc();
    test_halt();
    test_ovf_clear();
    test_async_reset();
`ifdef SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
